regfile_wb_demux: RTL and testbench



---
 rtl/rf_pkg.sv | 8 +
 rtl/dec_3to8.sv | 12 +
 rtl/regfile_wb_demux.sv | 67 ++++++
 tb/tb_regfile_wb_demux.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file sizing constants and word/address types
package rf_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;
    typedef logic [ADDR_W-1:0] raddr_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/dec_3to8.sv
// dec_3to8: register address to one-hot select, gated by an enable
module dec_3to8 #(
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int NREG   = rf_pkg::NREG
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot
);
    // one bit per register, all zero when disabled
    always_comb onehot = en ? {{(NREG-1){1'b0}}, 1'b1} << addr : '0;
endmodule

// File: rtl/regfile_wb_demux.sv
// regfile_wb_demux: write-back commit buffer, register file and pending scoreboard
module regfile_wb_demux #(
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int ADDR_W  = rf_pkg::ADDR_W,
    parameter int NREG    = rf_pkg::NREG,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   hold,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic [NREG-1:0]        pending,
    output logic                   commit,
    output logic [ADDR_W-1:0]      commit_addr,
    output logic [NREG*DATA_W-1:0] regs
);
    localparam logic [NREG-1:0] R0_MASK = NREG'(R0_ZERO);
    logic                             buf_full;
    logic [ADDR_W-1:0]                buf_addr;
    logic [DATA_W-1:0]                buf_data;
    logic [NREG-1:0][DATA_W-1:0]      rf;
    logic [NREG-1:0]                  wsel;
    logic [NREG-1:0]                  ssel;
    logic                             accept;
    logic                             do_commit;
    assign regs = rf;
    // handshake: a held full buffer blocks new write-backs
    always_comb begin
        wb_ready  = !rst && (!buf_full || !hold);
        accept    = wb_valid && wb_ready;
        do_commit = buf_full && !hold;
    end
    dec_3to8 #(.ADDR_W(ADDR_W), .NREG(NREG)) u_wdec (
        .en(do_commit), .addr(buf_addr), .onehot(wsel)
    );
    dec_3to8 #(.ADDR_W(ADDR_W), .NREG(NREG)) u_sdec (
        .en(iss_valid), .addr(iss_addr), .onehot(ssel)
    );
    // buffer, commit pulse, register writes and scoreboard; set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full    <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            rf          <= '0;
            pending     <= '0;
            commit      <= 1'b0;
            commit_addr <= '0;
        end else begin
            buf_full <= accept || (buf_full && hold);
            if (accept) begin
                buf_addr <= wb_addr;
                buf_data <= wb_data;
            end
            commit <= do_commit;
            if (do_commit) commit_addr <= buf_addr;
            for (int i = 0; i < NREG; i++)
                if (wsel[i] && !R0_MASK[i]) rf[i] <= buf_data;
            pending <= (pending & ~wsel) | (ssel & ~R0_MASK);
        end
    end
endmodule

// File: tb/tb_regfile_wb_demux.sv
// tb_regfile_wb_demux: directed stimulus with a commit scoreboard
module tb_regfile_wb_demux;
    logic         clk = 1'b0;
    logic         rst;
    logic         wb_valid;
    logic         wb_ready;
    logic [2:0]   wb_addr;
    logic [15:0]  wb_data;
    logic         hold;
    logic         iss_valid;
    logic [2:0]   iss_addr;
    logic [7:0]   pending;
    logic         commit;
    logic [2:0]   commit_addr;
    logic [127:0] regs;
    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    regfile_wb_demux dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .hold(hold),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pending(pending),
        .commit(commit), .commit_addr(commit_addr), .regs(regs)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask
    // monitor: every commit pulse must match the oldest expected write-back
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_commit", {125'b0, commit_addr}, 128'hx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_addr", {125'b0, commit_addr}, {125'b0, e.a});
                chk("commit_data", {112'b0, regs[commit_addr*16 +: 16]}, {112'b0, e.d});
            end
        end
    end
    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        hold = 1'b0; iss_valid = 1'b0; iss_addr = '0;
        step();
        step();
        chk("rst_regs", regs, 128'h0);
        chk("rst_pending", {120'b0, pending}, 128'h0);
        chk("rst_commit", {127'b0, commit}, 128'h0);
        chk("rst_commit_addr", {125'b0, commit_addr}, 128'h0);
        chk("rst_ready", {127'b0, wb_ready}, 128'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {127'b0, wb_ready}, 128'h1);
        // single write
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        push(3'd5, 16'hBEEF);
        step();
        wb_valid = 1'b0;
        chk("single_not_yet", regs, 128'h0);
        step();
        chk("single_regs", regs, {16'h0, 16'h0, 16'hBEEF, 80'h0});
        chk("single_commit", {127'b0, commit}, 128'h1);
        step();
        chk("single_commit_drop", {127'b0, commit}, 128'h0);
        chk("commit_addr_holds", {125'b0, commit_addr}, 128'h5);
        // back-to-back writes 1..7
        for (int a = 1; a < 8; a++) begin
            wb_valid = 1'b1; wb_addr = 3'(a); wb_data = 16'(16'h0011 * a);
            #1;
            chk("b2b_ready", {127'b0, wb_ready}, 128'h1);
            push(3'(a), 16'(16'h0011 * a));
            step();
        end
        wb_valid = 1'b0;
        step();
        step();
        chk("b2b_regs", regs, {16'h0077, 16'h0066, 16'h0055, 16'h0044,
                               16'h0033, 16'h0022, 16'h0011, 16'h0000});
        // hold with a full buffer
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        push(3'd3, 16'h1234);
        step();
        hold = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_ready", {127'b0, wb_ready}, 128'h0);
            chk("hold_reg3", {112'b0, regs[48 +: 16]}, {112'b0, 16'h0033});
            step();
        end
        hold = 1'b0;
        #1;
        chk("release_ready", {127'b0, wb_ready}, 128'h1);
        push(3'd4, 16'h4444);
        step();
        wb_valid = 1'b0;
        step();
        step();
        chk("hold_reg3_final", {112'b0, regs[48 +: 16]}, {112'b0, 16'h1234});
        chk("hold_reg4_final", {112'b0, regs[64 +: 16]}, {112'b0, 16'h4444});
        // scoreboard set and clear
        iss_valid = 1'b1; iss_addr = 3'd2;
        step();
        iss_valid = 1'b0;
        chk("pend_set", {120'b0, pending}, {120'b0, 8'b0000_0100});
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h2222;
        push(3'd2, 16'h2222);
        step();
        wb_valid = 1'b0;
        chk("pend_before_commit", {120'b0, pending}, {120'b0, 8'b0000_0100});
        step();
        chk("pend_cleared", {120'b0, pending}, 128'h0);
        // simultaneous set and clear on register 2
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h2A2A;
        push(3'd2, 16'h2A2A);
        step();
        wb_valid = 1'b0; iss_valid = 1'b1; iss_addr = 3'd2;
        step();
        iss_valid = 1'b0;
        chk("pend_set_wins", {120'b0, pending}, {120'b0, 8'b0000_0100});
        // register 0 is hardwired
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        iss_valid = 1'b1; iss_addr = 3'd0;
        push(3'd0, 16'h0000);
        step();
        wb_valid = 1'b0; iss_valid = 1'b0;
        chk("r0_not_pending", {120'b0, pending}, {120'b0, 8'b0000_0100});
        step();
        chk("r0_commit", {127'b0, commit}, 128'h1);
        chk("r0_zero", {112'b0, regs[15:0]}, 128'h0);
        step();
        // reset discards a held buffered write
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
        step();
        wb_valid = 1'b0; hold = 1'b1;
        step();
        chk("held_ready", {127'b0, wb_ready}, 128'h0);
        rst = 1'b1;
        #1;
        chk("rst_ready_low", {127'b0, wb_ready}, 128'h0);
        step();
        chk("mid_rst_regs", regs, 128'h0);
        chk("mid_rst_pending", {120'b0, pending}, 128'h0);
        chk("mid_rst_commit", {127'b0, commit}, 128'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {127'b0, wb_ready}, 128'h1);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_regs", regs, 128'h0);
        chk("queue_drained", 128'(q.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
